mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 MUL (low word), 01 MULH (s*s high), 10 MULHSU (s*u high), 11 MULHU (u*u high).
REQ-006 src1  input  32  multiplicand (rs1); sampled with start.
REQ-007 src2  input  32  multiplier (rs2); sampled with start.
REQ-008 busy  output  1  high from the cycle after accepted start until done, inclusive.
REQ-009 done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-010 result  output  32  product word selected by op; held until the next accepted start.

Function
REQ-011 The block shall instantiate exactly one 8x8 unsigned combinational multiplier (wallace) and reuse it on every CALC cycle; no other multiplier shall be inferred.
REQ-012 States: IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after 16th iteration, FIX->DONE, DONE->IDLE unconditionally.
REQ-013 On accept: latch op; latch |src1| if op is 01/10, else src1 raw; latch |src2| if op is 01, else src2 raw; latch neg = sign1 XOR sign2 under the same signedness rules; clear 64-bit accumulator and 4-bit counter k.
REQ-014 CALC iteration k (0..15): i = k[1:0], j = k[3:2]; accumulator += wallace(a_byte[i], b_byte[j]) << 8*(i+j), modulo 2^64.
REQ-015 Magnitude of 0x80000000 shall be 0x80000000 treated as unsigned 32 bits.
REQ-016 FIX: if neg, accumulator <= two's complement of accumulator (64-bit); else unchanged.
REQ-017 DONE: result <= accumulator[31:0] for op 00, else accumulator[63:32]; done = 1 in this cycle only.
REQ-018 Latency: start sampled at edge N -> done high in cycle N+18, busy high cycles N+1..N+18.
REQ-019 start while busy shall be ignored with no effect on state, operands or result.
REQ-020 start in the DONE cycle is ignored; a new request is accepted at earliest the cycle after done.
REQ-021 op, src1, src2 changes while busy shall not affect the in-flight product.

Reset
REQ-022 On rst at any clock edge, including mid-CALC/FIX/DONE: state IDLE, busy 0, done 0, result 0x00000000, accumulator 0, counter 0, neg 0.
REQ-023 rst has priority over start in the same cycle; the request is dropped.

Configuration
REQ-024 Macro MUL_EARLY_OUT_EN: when defined, an accepted start with src1 == 0 or src2 == 0 shall go IDLE->DONE directly, result 0, done in cycle N+2, busy cycles N+1..N+2.
REQ-025 Without MUL_EARLY_OUT_EN, zero operands take the full 18-cycle path and yield result 0.

Verification
REQ-026 op=00, src1=3, src2=5 -> done at N+18, result=0x0000000F.
REQ-027 op=11, src1=src2=0xFFFFFFFF -> result=0xFFFFFFFE; op=00 same operands -> 0x00000001.
REQ-028 op=01, src1=src2=0x80000000 -> result=0x40000000; op=10, src1=0xFFFFFFFF, src2=2 -> result=0xFFFFFFFF.
REQ-029 op=00, src1=0x12345678, src2=0x9ABCDEF0 -> result=0x242D2080; start pulsed again at N+5 with other operands -> ignored, same result at N+18.
REQ-030 rst asserted at N+9 mid-CALC -> next cycle busy=0, done=0, result=0; new start at N+11 completes normally at N+29.
REQ-031 MUL_EARLY_OUT_EN defined, op=01, src1=0, src2=0xDEADBEEF -> done at N+2, result=0; undefined -> done at N+18, result=0.

Source files
------------

// File: rtl/mul_seq.sv
// mul_seq: sequential 32x32 multiplier for the RISC-V M-extension multiply ops.
// One 8x8 Wallace-tree multiplier is reused across 16 CALC cycles (one byte-pair
// per cycle), then a FIX cycle applies the product sign and a DONE cycle
// presents the selected word.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE
//   op     in   [1:0] 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   src1   in   [31:0] multiplicand (rs1)
//   src2   in   [31:0] multiplier (rs2)
//   busy   out  high from the cycle after accept through the done cycle
//   done   out  one-cycle pulse, result valid in the same cycle
//   result out  [31:0] selected product word, held until the next result
//
// Build option: define MUL_EARLY_OUT_EN to skip the iteration when either
// operand is zero (done two cycles after accept, result 0).

// 8x8 unsigned multiplier built as a carry-save (Wallace) reduction tree.
module mul_seq_wallace8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  localparam int unsigned PW = 16;

  // 3:2 compressor on whole words: {carry, sum}. Every operand is a
  // non-negative piece of a product < 2^16, so the dropped carry MSB is zero.
  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                          input logic [PW-1:0] y,
                                          input logic [PW-1:0] z);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    s = x ^ y ^ z;
    c = PW'(((x & y) | (x & z) | (y & z)) << 1);
    return {c, s};
  endfunction

  logic [PW-1:0] pp [8];
  logic [PW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      pp[r] = b_i[r] ? PW'(PW'(a_i) << r) : '0;
    end
    // 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
    {c0, s0} = csa(pp[0], pp[1], pp[2]);
    {c1, s1} = csa(pp[3], pp[4], pp[5]);
    {c2, s2} = csa(s0, c0, s1);
    {c3, s3} = csa(c1, pp[6], pp[7]);
    {c4, s4} = csa(s2, c2, s3);
    {c5, s5} = csa(s4, c4, c3);
    p_o = s5 + c5;
  end

endmodule

module mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned XW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned KW = 4;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [XW-1:0] a_q, a_d;
  logic [XW-1:0] b_q, b_d;
  logic          neg_q, neg_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic [XW-1:0] result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept_c;
  logic          sgn1_c, sgn2_c;
  logic [XW-1:0] mag1_c, mag2_c;
  logic [1:0]    i_c, j_c;
  logic [7:0]    a_byte_c, b_byte_c;
  logic [15:0]   pp_c;
  logic [5:0]    shamt_c;
  logic [AW-1:0] acc_fix_c;

  assign accept_c = (state_q == S_IDLE) && start;

`ifdef MUL_EARLY_OUT_EN
  logic zero_op_c;
  assign zero_op_c = (src1 == '0) || (src2 == '0);
`endif

  // Operand magnitudes; 0x80000000 maps to itself as an unsigned value.
  assign sgn1_c = ((op == OP_MULH) || (op == OP_MULHSU)) && src1[XW-1];
  assign sgn2_c = (op == OP_MULH) && src2[XW-1];
  assign mag1_c = sgn1_c ? XW'(~src1 + XW'(1)) : src1;
  assign mag2_c = sgn2_c ? XW'(~src2 + XW'(1)) : src2;

  // Iteration k walks a bytes fastest: i = k[1:0], j = k[3:2].
  assign i_c      = k_q[1:0];
  assign j_c      = k_q[3:2];
  assign a_byte_c = a_q[8*i_c +: 8];
  assign b_byte_c = b_q[8*j_c +: 8];
  assign shamt_c  = {3'(3'(i_c) + 3'(j_c)), 3'b000};

  mul_seq_wallace8 u_wallace (
    .a_i (a_byte_c),
    .b_i (b_byte_c),
    .p_o (pp_c)
  );

  assign acc_fix_c = neg_q ? AW'(~acc_q + AW'(1)) : acc_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MUL_EARLY_OUT_EN
          // Zero operand: one settling cycle in FIX (acc is 0), then DONE.
          state_d = zero_op_c ? S_FIX : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC:  if (k_q == KW'(15)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: status flags registered from the upcoming state.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d != S_IDLE) busy_d = 1'b1;
    if (state_d == S_DONE) done_d = 1'b1;
  end

  // Datapath next-state.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;
    if (accept_c) begin
      op_d  = op;
      a_d   = mag1_c;
      b_d   = mag2_c;
      neg_d = sgn1_c ^ sgn2_c;
      acc_d = '0;
      k_d   = '0;
    end else if (state_q == S_CALC) begin
      acc_d = acc_q + AW'(AW'(pp_c) << shamt_c);
      k_d   = k_q + KW'(1);
    end else if (state_q == S_FIX) begin
      // Result is loaded with the signed fix so it is valid alongside done.
      acc_d    = acc_fix_c;
      result_d = (op_q == OP_MUL) ? acc_fix_c[XW-1:0] : acc_fix_c[AW-1:XW];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a scoreboard of {result, done cycle} is
// filled as requests are driven and drained by a monitor on done.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   early  = 1'b0;

  mul_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model using sign/zero-extended 64-bit products.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    y = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p = x * y;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%h required no done", cyc, result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || cyc != e.cyc) begin
          errors++;
          $display("FAIL done_result got=%h@%0d required=%h@%0d", result, cyc, e.res, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
    exp_t e;
    int   lat;
    lat = (early && (a == 0 || b == 0)) ? 2 : 18;
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    e.res = expv; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    // Scramble inputs while busy; the in-flight product must not see them.
    start = 1'b0; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    issue(2'b00, 32'd3, 32'd5, 32'h0000000F);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept got=%b required 1", busy);
    end
    wait_idle("basic");
  endtask

  task automatic test_corners();
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE); wait_idle("mulhu_max");
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001); wait_idle("mul_max");
    issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000); wait_idle("mulh_min");
    issue(2'b10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF); wait_idle("mulhsu_neg");
    issue(2'b01, 32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF); wait_idle("mulh_neg");
    issue(2'b10, 32'd2,        32'hFFFFFFFF, 32'h00000001); wait_idle("mulhsu_pos");
  endtask

  task automatic test_ignore_busy();
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; src1 = 32'hCAFEF00D; src2 = 32'h0BADBEEF;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore_busy");
  endtask

  task automatic test_done_cycle_start();
    logic [31:0] r;
    r = model(2'b01, 32'hDEADBEEF, 32'h01234567);
    issue(2'b01, 32'hDEADBEEF, 32'h01234567, r);
    while (!done && busy) @(negedge clk);
    // Request presented during the done cycle must be dropped.
    start = 1'b1; op = 2'b00; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== r) begin
      errors++;
      $display("FAIL start_in_done busy=%b result=%h required 0/%h", busy, result, r);
    end
    wait_idle("done_cycle");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'(t);
      a = $urandom; b = $urandom;
      if (t == 4) a = 32'h80000000;
      issue(o, a, b, model(o, a, b));
      wait_idle("back_to_back");
    end
  endtask

  task automatic test_rst_mid();
    issue(2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid busy=%b done=%b result=%h required 0/0/0", busy, done, result);
    end
    issue(2'b11, 32'h10000000, 32'h00000030, 32'h00000003);
    wait_idle("after_rst");
    // rst together with start: request dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'b00; src1 = 32'd4; src2 = 32'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL rst_over_start busy=%b result=%h required 0/0", busy, result);
    end
  endtask

  task automatic test_zero();
    issue(2'b01, 32'h0, 32'hDEADBEEF, 32'h0);
    wait_idle("zero_src1");
    issue(2'b00, 32'h12345678, 32'h0, 32'h0);
    wait_idle("zero_src2");
  endtask

  initial begin
`ifdef MUL_EARLY_OUT_EN
    early = 1'b1;
`endif
    test_reset();
    test_basic();
    test_corners();
    test_ignore_busy();
    test_done_cycle_start();
    test_back_to_back();
    test_rst_mid();
    test_zero();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
